// File: rtl/fixed_sample_fifo.sv
// fixed_sample_fifo
//   Receive-side FIFO for fixed-point samples. Each accepted sample is
//   rescaled from (IN_WIDTH, IN_EXP) to (OUT_WIDTH, OUT_EXP) as it is written.
//   The head entry is presented on a registered, first-word-fall-through read
//   port. While the FIFO is empty, the read port shows INIT quantised to the
//   output format.
//
//   Build option: define FIXED_SAMPLE_FIFO_SAT_EN to clamp out-of-range
//   conversions and raise the sticky sat_o flag. Without it, conversions keep
//   the low OUT_WIDTH bits and sat_o is tied low.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset (wins over cke_i)
//   cke_i        clock enable, low freezes all state
//   in_data_i    signed input sample, value = in_data_i * 2^IN_EXP
//   in_valid_i   input sample valid
//   in_ready_o   input accept (cke_i & not full)
//   out_data_o   converted head sample, or INIT_Q when empty
//   out_valid_o  head sample valid (FIFO non-empty)
//   out_ready_i  consumer accept
//   count_o      occupancy
//   sat_o        sticky saturation flag
module fixed_sample_fifo #(
  parameter int  IN_WIDTH  = 16,
  parameter int  IN_EXP    = -8,
  parameter int  OUT_WIDTH = 17,
  parameter int  OUT_EXP   = -9,
  parameter int  DEPTH     = 4,
  parameter real INIT      = 0.0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cke_i,
  input  logic signed [IN_WIDTH-1:0]   in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic signed [OUT_WIDTH-1:0]  out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         sat_o
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int S    = IN_EXP - OUT_EXP;
  localparam int SP   = (S > 0) ? S : 0;
  localparam int SN   = (S < 0) ? -S : 0;
  localparam int IW   = IN_WIDTH + SP;
  localparam int CW   = (IW > OUT_WIDTH) ? IW : OUT_WIDTH;

  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [PW-1:0]   LAST_P  = PW'(DEPTH - 1);

  // floor(r * 2^-OUT_EXP), clamped to the signed output range.
  function automatic logic signed [OUT_WIDTH-1:0] init_q_calc(input real r);
    real    v;
    longint t;
    longint hi;
    longint lo;
    v = r;
    if (OUT_EXP < 0) begin
      for (int i = 0; i < -OUT_EXP; i++) v = v * 2.0;
    end else begin
      for (int i = 0; i < OUT_EXP; i++) v = v / 2.0;
    end
    // longint' rounds to nearest, so step down once if it rounded up.
    t = longint'(v);
    if (real'(t) > v) t = t - 1;
    hi = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
    lo = -hi - 1;
    if (t > hi) t = hi;
    if (t < lo) t = lo;
    return OUT_WIDTH'(t);
  endfunction

  localparam logic signed [OUT_WIDTH-1:0] INIT_Q = init_q_calc(INIT);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // Write-time format conversion
  // ---------------------------------------------------------------------
  logic signed [IW-1:0]        ext_w;
  logic signed [IW-1:0]        shifted_w;
  logic signed [CW-1:0]        wide_w;
  logic signed [OUT_WIDTH-1:0] conv_w;

`ifdef FIXED_SAMPLE_FIFO_SAT_EN
  localparam logic signed [CW-1:0] MAX_W = CW'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [CW-1:0] MIN_W = ~MAX_W;
  localparam logic signed [OUT_WIDTH-1:0] MAX_O = OUT_WIDTH'(MAX_W);
  localparam logic signed [OUT_WIDTH-1:0] MIN_O = ~MAX_O;
  logic clamp_w;
`endif

  always_comb begin
    ext_w     = IW'(in_data_i);
    // At most one of SP/SN is non-zero; the right shift is arithmetic, so
    // discarded fraction bits floor toward -inf.
    shifted_w = (ext_w <<< SP) >>> SN;
    wide_w    = CW'(shifted_w);
`ifdef FIXED_SAMPLE_FIFO_SAT_EN
    clamp_w = 1'b0;
    conv_w  = OUT_WIDTH'(wide_w);
    if (wide_w > MAX_W) begin
      conv_w  = MAX_O;
      clamp_w = 1'b1;
    end else if (wide_w < MIN_W) begin
      conv_w  = MIN_O;
      clamp_w = 1'b1;
    end
`else
    conv_w = OUT_WIDTH'(wide_w);
`endif
  end

  // ---------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------
  logic [OUT_WIDTH-1:0]        mem_q [DEPTH];
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]             count_q, count_d;
  logic signed [OUT_WIDTH-1:0] head_q, head_d;
  logic                        push_w, pop_w;

  assign in_ready_o  = cke_i & (count_q < DEPTH_C);
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = head_q;
  assign count_o     = count_q;

  assign push_w = in_valid_i & in_ready_o;
  assign pop_w  = out_valid_o & out_ready_i & cke_i;

  always_comb begin
    rd_ptr_d = pop_w  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_w ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    if (push_w && !pop_w) count_d = count_q + 1'b1;
    else if (pop_w && !push_w) count_d = count_q - 1'b1;
    // The head register tracks the entry that will sit at rd_ptr after this
    // edge. If that slot is being written right now, take the converted
    // sample directly rather than the stale memory word.
    if (count_d == '0) head_d = INIT_Q;
    else if (push_w && (rd_ptr_d == wr_ptr_q)) head_d = conv_w;
    else head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (push_w) mem_q[wr_ptr_q] <= conv_w;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= INIT_Q;
    end else if (cke_i) begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

`ifdef FIXED_SAMPLE_FIFO_SAT_EN
  logic sat_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) sat_q <= 1'b0;
    else if (push_w && clamp_w) sat_q <= 1'b1;
  end
  assign sat_o = sat_q;
`else
  assign sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_fixed_sample_fifo.sv
// Bench for fixed_sample_fifo. Three instances run side by side:
//   k0: default formats (x2 scaling), DEPTH 4, INIT 0.0
//   k1: OUT_EXP -6 (divide by 4, floor), DEPTH 3, INIT 0.0
//   k2: OUT_WIDTH 12, OUT_EXP -9, DEPTH 4, INIT -0.25
// A queue-style model predicts every output on every cycle; directed steps
// pin the model with hand-computed values.
module tb_fixed_sample_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst, cke, vld, rdy;
  logic signed [15:0] din [3];

  wire [2:0]          irdy, ovld, satv;
  wire signed [16:0]  dout0, dout1;
  wire signed [11:0]  dout2;
  wire [2:0]          cnt0, cnt2;
  wire [1:0]          cnt1;

  int checks   = 0;
  int failures = 0;

  fixed_sample_fifo u0 (
    .clk_i(clk), .rst_i(rst[0]), .cke_i(cke[0]), .in_data_i(din[0]),
    .in_valid_i(vld[0]), .in_ready_o(irdy[0]), .out_data_o(dout0),
    .out_valid_o(ovld[0]), .out_ready_i(rdy[0]), .count_o(cnt0), .sat_o(satv[0]));

  fixed_sample_fifo #(.OUT_EXP(-6), .DEPTH(3)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .cke_i(cke[1]), .in_data_i(din[1]),
    .in_valid_i(vld[1]), .in_ready_o(irdy[1]), .out_data_o(dout1),
    .out_valid_o(ovld[1]), .out_ready_i(rdy[1]), .count_o(cnt1), .sat_o(satv[1]));

  fixed_sample_fifo #(.OUT_WIDTH(12), .INIT(-0.25)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .cke_i(cke[2]), .in_data_i(din[2]),
    .in_valid_i(vld[2]), .in_ready_o(irdy[2]), .out_data_o(dout2),
    .out_valid_o(ovld[2]), .out_ready_i(rdy[2]), .count_o(cnt2), .sat_o(satv[2]));

  // Per-instance configuration
  function automatic int ow(input int k);
    return (k == 2) ? 12 : 17;
  endfunction
  function automatic int oe(input int k);
    return (k == 1) ? -6 : -9;
  endfunction
  function automatic int dep(input int k);
    return (k == 1) ? 3 : 4;
  endfunction
  // floor(INIT * 2^-OUT_EXP): 0 for k0/k1, floor(-0.25 * 512) = -128 for k2
  function automatic longint initq(input int k);
    return (k == 2) ? -128 : 0;
  endfunction

  function automatic longint dout(input int k);
    case (k)
      0: return longint'(dout0);
      1: return longint'(dout1);
      default: return longint'(dout2);
    endcase
  endfunction
  function automatic longint dcnt(input int k);
    case (k)
      0: return longint'(cnt0);
      1: return longint'(cnt1);
      default: return longint'(cnt2);
    endcase
  endfunction

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s k%0d got=%0d expected=%0d", name, k, act, exp);
    end
  endtask

  // value * 2^(IN_EXP-OUT_EXP) with floor, then clamp or wrap to OUT_WIDTH
  task automatic conv(input int k, input longint x, output longint v, output bit clamped);
    int     s;
    longint d, hi, lo, p;
    s = -8 - oe(k);
    if (s >= 0) v = x * (longint'(1) << s);
    else begin
      d = longint'(1) << (-s);
      v = (x >= 0) ? x / d : -((-x + d - 1) / d);
    end
    hi = (longint'(1) << (ow(k) - 1)) - 1;
    lo = -hi - 1;
    clamped = (v > hi) || (v < lo);
`ifdef FIXED_SAMPLE_FIFO_SAT_EN
    if (v > hi) v = hi;
    if (v < lo) v = lo;
`else
    p = longint'(1) << ow(k);
    v = v % p;
    if (v < 0) v = v + p;
    if (v > hi) v = v - p;
`endif
  endtask

  // Model: ordered list of converted samples per instance
  longint mdata [3][8];
  int     msize [3];
  bit     msat  [3];
  bit     mlive [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      msize[k] = 0; msat[k] = 1'b0; mlive[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        bit     do_push, do_pop, c;
        longint v;
        if (mlive[k]) begin
          chk("out_valid", k, longint'(ovld[k]), longint'(msize[k] != 0));
          chk("out_data", k, dout(k), (msize[k] != 0) ? mdata[k][0] : initq(k));
          chk("count", k, dcnt(k), longint'(msize[k]));
          chk("in_ready", k, longint'(irdy[k]), longint'(cke[k] && (msize[k] < dep(k))));
          chk("sat", k, longint'(satv[k]), longint'(msat[k]));
        end
        // Predict the effect of the coming rising edge
        if (rst[k]) begin
          msize[k] = 0; msat[k] = 1'b0; mlive[k] = 1'b1;
        end else if (mlive[k] && cke[k]) begin
          do_pop  = (msize[k] > 0) && rdy[k];
          do_push = vld[k] && (msize[k] < dep(k));
          if (do_pop) begin
            for (int i = 0; i < 7; i++) mdata[k][i] = mdata[k][i+1];
            msize[k]--;
          end
          if (do_push) begin
            conv(k, longint'(din[k]), v, c);
            mdata[k][msize[k]] = v;
            msize[k]++;
`ifdef FIXED_SAMPLE_FIFO_SAT_EN
            if (c) msat[k] = 1'b1;
`endif
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t2_in  [4];
  int t2_out [4];

  initial begin
    rst = '1; cke = '1; vld = '0; rdy = '0;
    for (int k = 0; k < 3; k++) din[k] = '0;
    tick(); tick();
    rst = '0;
    tick();

    // 384 (1.5) -> 768 after one edge, then pop back to INIT_Q
    din[0] = 16'sd384; vld[0] = 1'b1; tick(); vld[0] = 1'b0;
    chk("t1_data", 0, dout(0), 768);
    chk("t1_valid", 0, longint'(ovld[0]), 1);
    chk("t1_count", 0, dcnt(0), 1);
    rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
    chk("t1_pop_data", 0, dout(0), 0);
    chk("t1_pop_valid", 0, longint'(ovld[0]), 0);

    // Fill, refused 5th push, no bypass on pop when full, ordered drain
    t2_in  = '{-128, 1, 32767, -32768};
    t2_out = '{-256, 2, 65534, -65536};
    vld[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din[0] = 16'(t2_in[i]);
      tick();
    end
    chk("t2_ready_full", 0, longint'(irdy[0]), 0);
    chk("t2_count_full", 0, dcnt(0), 4);
    din[0] = 16'sd1234; tick();
    chk("t2_refused", 0, dcnt(0), 4);
    chk("t2_drain0", 0, dout(0), t2_out[0]);
    rdy[0] = 1'b1; tick(); vld[0] = 1'b0;
    chk("t2_no_bypass", 0, dcnt(0), 3);
    for (int i = 1; i < 4; i++) begin
      chk("t2_drain", 0, dout(0), t2_out[i]);
      tick();
    end
    rdy[0] = 1'b0;
    chk("t2_empty", 0, longint'(ovld[0]), 0);

    // Right shift floors toward -inf
    vld[1] = 1'b1;
    din[1] = 16'sd385; tick();
    din[1] = -16'sd1;  tick();
    din[1] = 16'sd3;   tick();
    vld[1] = 1'b0;
    chk("t3_ready_full", 1, longint'(irdy[1]), 0);
    chk("t3_385", 1, dout(1), 96);
    rdy[1] = 1'b1; tick();
    chk("t3_m1", 1, dout(1), -1);
    tick();
    chk("t3_3", 1, dout(1), 0);
    chk("t3_3_valid", 1, longint'(ovld[1]), 1);
    tick(); rdy[1] = 1'b0;
    chk("t3_empty", 1, longint'(ovld[1]), 0);

    // 12-bit output: 1100 * 2 = 2200 is out of range
    din[2] = 16'sd1100; vld[2] = 1'b1; tick();
    din[2] = 16'sd5; tick(); vld[2] = 1'b0;
`ifdef FIXED_SAMPLE_FIFO_SAT_EN
    chk("t4_out", 2, dout(2), 2047);
    chk("t4_sat", 2, longint'(satv[2]), 1);
`else
    chk("t4_out", 2, dout(2), -1896);
    chk("t4_sat", 2, longint'(satv[2]), 0);
`endif
    rdy[2] = 1'b1; tick();
    chk("t4_next", 2, dout(2), 10);
    tick(); rdy[2] = 1'b0;
`ifdef FIXED_SAMPLE_FIFO_SAT_EN
    chk("t4_sat_sticky", 2, longint'(satv[2]), 1);
`else
    chk("t4_sat_sticky", 2, longint'(satv[2]), 0);
`endif

    // Reset mid-operation discards contents
    vld[2] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      din[2] = 16'(i); tick();
    end
    vld[2] = 1'b0;
    chk("t6_count_pre", 2, dcnt(2), 3);
    rst[2] = 1'b1; tick(); rst[2] = 1'b0;
    chk("t6_count", 2, dcnt(2), 0);
    chk("t6_valid", 2, longint'(ovld[2]), 0);
    chk("t6_init", 2, dout(2), -128);
    chk("t6_sat", 2, longint'(satv[2]), 0);

    // Steady push+pop at count 2 across pointer wrap, with a freeze
    vld[0] = 1'b1; vld[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din[0] = 16'(40 + i); din[1] = 16'(400 + 4 * i); tick();
    end
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        cke[0] = 1'b0; cke[1] = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          chk("t5_freeze_count", 0, dcnt(0), 2);
          chk("t5_freeze_count", 1, dcnt(1), 2);
        end
        cke[0] = 1'b1; cke[1] = 1'b1;
      end
      din[0] = 16'(50 + i); din[1] = 16'(500 + 4 * i - 7 * (i % 3)); tick();
      chk("t5_hold", 0, dcnt(0), 2);
      chk("t5_hold", 1, dcnt(1), 2);
    end
    vld[0] = 1'b0; vld[1] = 1'b0; rdy[0] = 1'b0; rdy[1] = 1'b0;
    // Last two pushes were 68 and 69 -> head is 68*2 = 136
    chk("t5_head", 0, dout(0), 136);
    rdy[0] = 1'b1; rdy[1] = 1'b1; tick(); tick(); tick();
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    chk("t5_drained", 0, dcnt(0), 0);
    chk("t5_drained", 1, dcnt(1), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
